// File: rtl/nanosoc_pad_gpio_ctrl_if.sv
// ----------------------------------------------------------------------------
// nanosoc_pad_gpio_ctrl_if
// Register-access bus between the SoC GPIO/APB glue and the pad-bank controller.
//
// Signals
//   wr_en    1      one-cycle register write strobe
//   wr_sel   2      write target: 0=DATAOUT 1=OUTEN 2=IRQCLR (W1C) 3=DBTHR
//   wr_data  PINS   write data (DBTHR takes the low DEBOUNCE_W bits)
//   rd_sel   2      read target: 0=DATAOUT 1=OUTEN 2=IRQSTAT 3=IN_DATA
//   rd_data  PINS   combinational read data selected by rd_sel
//
// Modports
//   master   the glue logic that issues writes and reads
//   slave    the pad-bank controller
// ----------------------------------------------------------------------------
interface nanosoc_pad_gpio_ctrl_if #(
    parameter int PINS = 16
);
    logic            wr_en;
    logic [1:0]      wr_sel;
    logic [PINS-1:0] wr_data;
    logic [1:0]      rd_sel;
    logic [PINS-1:0] rd_data;

    modport master (
        output wr_en,
        output wr_sel,
        output wr_data,
        output rd_sel,
        input  rd_data
    );

    modport slave (
        input  wr_en,
        input  wr_sel,
        input  wr_data,
        input  rd_sel,
        output rd_data
    );
endinterface

// File: rtl/nanosoc_pad_gpio_ctrl.sv
// ----------------------------------------------------------------------------
// nanosoc_pad_gpio_ctrl
// Core-side driver/receiver for a bank of bidirectional pads whose output
// enable is active low. Output data and NOE come straight from flops. The pad
// input passes through a synchroniser and a per-pin debounce; every change of
// the debounced level (either direction) sets a sticky interrupt status bit.
//
// Parameters
//   PINS         number of pads in the bank
//   SYNC_STAGES  input synchroniser depth (>= 2)
//   DEBOUNCE_W   width of the debounce threshold and per-pin counters
//
// Ports
//   HCLK      in   clock
//   HRESETn   in   synchronous active-low reset
//   bus       slave modport of nanosoc_pad_gpio_ctrl_if (register writes/reads)
//   pad_o     out  pad output data (DATAOUT)
//   pad_noe   out  pad output enable, 0 = drive, 1 = tri-state (~OUTEN)
//   pad_i     in   pad input, asynchronous to HCLK
//   in_data   out  synchronised, debounced input level
//   irq       out  OR of the interrupt status bits
//   conflict  out  sticky drive-conflict flags
//
// Build option
//   NANOSOC_PAD_CONFLICT_DET_EN  when defined, a pin that is driven with a
//   settled value but reads back the opposite level for two consecutive
//   cycles raises its conflict flag; otherwise conflict is tied to 0.
// ----------------------------------------------------------------------------
module nanosoc_pad_gpio_ctrl #(
    parameter int PINS        = 16,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_W  = 8
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    nanosoc_pad_gpio_ctrl_if.slave bus,
    output logic [PINS-1:0]        pad_o,
    output logic [PINS-1:0]        pad_noe,
    input  logic [PINS-1:0]        pad_i,
    output logic [PINS-1:0]        in_data,
    output logic                   irq,
    output logic [PINS-1:0]        conflict
);

    logic [PINS-1:0]       data_out;
    logic [PINS-1:0]       noe_q;
    logic [PINS-1:0]       irq_stat;
    logic [DEBOUNCE_W-1:0] dbthr;
    logic [PINS-1:0]       sync_q [SYNC_STAGES];
    logic [PINS-1:0]       stable_q;
    logic [DEBOUNCE_W-1:0] cnt_q  [PINS];

    logic [DEBOUNCE_W-1:0] cnt_d  [PINS];
    logic [PINS-1:0]       stable_d;
    logic [PINS-1:0]       edge_set;
    logic [PINS-1:0]       s;
    logic [PINS-1:0]       irq_clr;
    logic                  dout_wr;
    logic                  outen_wr;
    logic                  dbthr_wr;
    logic [DEBOUNCE_W-1:0] thr_m1;

    assign s        = sync_q[SYNC_STAGES-1];
    assign dout_wr  = bus.wr_en && (bus.wr_sel == 2'd0);
    assign outen_wr = bus.wr_en && (bus.wr_sel == 2'd1);
    assign dbthr_wr = bus.wr_en && (bus.wr_sel == 2'd3);
    assign irq_clr  = (bus.wr_en && (bus.wr_sel == 2'd2)) ? bus.wr_data : '0;

    // A threshold of 0 behaves like 1, so the terminal count is never below 0.
    assign thr_m1 = (dbthr == '0) ? '0 : dbthr - DEBOUNCE_W'(1);

    // Per-pin debounce: the synchronised level must differ from the accepted
    // level for T consecutive cycles before it is adopted. A threshold write
    // discards every partial count so no pin inherits a count made against the
    // old threshold.
    always_comb begin
        stable_d = stable_q;
        edge_set = '0;
        for (int i = 0; i < PINS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (dbthr_wr) begin
                cnt_d[i] = '0;
            end else if (s[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == thr_m1) begin
                stable_d[i] = s[i];
                cnt_d[i]    = '0;
                edge_set[i] = 1'b1;
            end else if (cnt_q[i] != '1) begin
                cnt_d[i] = cnt_q[i] + DEBOUNCE_W'(1);
            end
        end
    end

    // NOE is held as its own flop (reset to all ones) so the pad pins have no
    // logic between the register and the pad ring. Status set wins over W1C.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            data_out <= '0;
            noe_q    <= '1;
            irq_stat <= '0;
            dbthr    <= DEBOUNCE_W'(1);
            stable_q <= '0;
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            for (int i = 0; i < PINS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            if (dout_wr) begin
                data_out <= bus.wr_data;
            end
            if (outen_wr) begin
                noe_q <= ~bus.wr_data;
            end
            if (dbthr_wr) begin
                dbthr <= bus.wr_data[DEBOUNCE_W-1:0];
            end
            sync_q[0] <= pad_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            stable_q <= stable_d;
            for (int i = 0; i < PINS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            irq_stat <= (irq_stat & ~irq_clr) | edge_set;
        end
    end

`ifdef NANOSOC_PAD_CONFLICT_DET_EN
    localparam int AGE_MAX = SYNC_STAGES + 1;
    localparam int AGE_W   = $clog2(SYNC_STAGES + 2);

    logic [AGE_W-1:0] age_q [PINS];
    logic [PINS-1:0]  miss_q;
    logic [PINS-1:0]  conflict_q;
    logic [PINS-1:0]  mismatch;
    logic [PINS-1:0]  outen;

    assign outen = ~noe_q;

    // The read-back is only trusted once the driven value has had time to
    // travel through the synchroniser, so each pin tracks how long its driven
    // value has been steady.
    always_comb begin
        mismatch = '0;
        for (int i = 0; i < PINS; i++) begin
            mismatch[i] = outen[i] && (age_q[i] == AGE_W'(AGE_MAX)) &&
                          (s[i] != data_out[i]);
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            miss_q     <= '0;
            conflict_q <= '0;
            for (int i = 0; i < PINS; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < PINS; i++) begin
                if (!outen[i] || (dout_wr && (bus.wr_data[i] != data_out[i]))) begin
                    age_q[i] <= '0;
                end else if (age_q[i] != AGE_W'(AGE_MAX)) begin
                    age_q[i] <= age_q[i] + AGE_W'(1);
                end
            end
            miss_q     <= mismatch;
            conflict_q <= (conflict_q & ~irq_clr) | (mismatch & miss_q);
        end
    end

    assign conflict = conflict_q;
`else
    assign conflict = '0;
`endif

    always_comb begin
        case (bus.rd_sel)
            2'd0:    bus.rd_data = data_out;
            2'd1:    bus.rd_data = ~noe_q;
            2'd2:    bus.rd_data = irq_stat;
            default: bus.rd_data = stable_q;
        endcase
    end

    assign pad_o   = data_out;
    assign pad_noe = noe_q;
    assign in_data = stable_q;
    assign irq     = |irq_stat;

endmodule

// File: tb/tb_nanosoc_pad_gpio_ctrl.sv
// ----------------------------------------------------------------------------
// tb_nanosoc_pad_gpio_ctrl
// Directed bench for nanosoc_pad_gpio_ctrl. Driven pads loop their output back
// onto pad_i; released pads (or pads in force_mask) read ext_in instead.
// ----------------------------------------------------------------------------
module tb_nanosoc_pad_gpio_ctrl;

`ifdef NANOSOC_PAD_CONFLICT_DET_EN
    localparam bit CONF_EN = 1'b1;
`else
    localparam bit CONF_EN = 1'b0;
`endif

    logic        HCLK;
    logic        HRESETn;
    logic [15:0] pad_o;
    logic [15:0] pad_noe;
    logic [15:0] pad_i;
    logic [15:0] in_data;
    logic        irq;
    logic [15:0] conflict;
    logic [15:0] ext_in;
    logic [15:0] force_mask;

    int total;
    int bad;

    nanosoc_pad_gpio_ctrl_if #(.PINS(16)) bus ();

    nanosoc_pad_gpio_ctrl #(
        .PINS(16),
        .SYNC_STAGES(2),
        .DEBOUNCE_W(8)
    ) dut (
        .HCLK(HCLK),
        .HRESETn(HRESETn),
        .bus(bus),
        .pad_o(pad_o),
        .pad_noe(pad_noe),
        .pad_i(pad_i),
        .in_data(in_data),
        .irq(irq),
        .conflict(conflict)
    );

    // Pad model: driven and unforced pins read back their own output.
    assign pad_i = (~pad_noe & ~force_mask & pad_o) | ((pad_noe | force_mask) & ext_in);

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance n rising edges and park 1 ns after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One-cycle register write; returns 1 ns after the edge that captured it.
    task automatic applyStimulus(input logic [1:0] sel, input logic [15:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_data = data;
        tick(1);
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
    endtask

    task automatic checkRead(input string tag, input logic [1:0] sel, input logic [15:0] exp);
        bus.rd_sel = sel;
        #1;
        checkOutput(tag, {16'h0, bus.rd_data}, {16'h0, exp});
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        HRESETn     = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_sel  = 2'd0;
        bus.wr_data = '0;
        bus.rd_sel  = 2'd0;
        ext_in      = '0;
        force_mask  = '0;

        // Reset state.
        tick(3);
        HRESETn = 1'b1;
        checkOutput("rst_noe", pad_noe, 16'hFFFF);
        checkOutput("rst_pad_o", pad_o, 16'h0000);
        checkOutput("rst_in_data", in_data, 16'h0000);
        checkOutput("rst_irq", irq, 1'b0);
        checkOutput("rst_conflict", conflict, 16'h0000);
        checkRead("rst_rd_in", 2'd3, 16'h0000);
        checkRead("rst_rd_outen", 2'd1, 16'h0000);

        // Drive the low byte and watch it loop back after 2 sync + 1 debounce edges.
        applyStimulus(2'd1, 16'h00FF);
        applyStimulus(2'd0, 16'h00A5);
        checkOutput("drv_noe", pad_noe, 16'hFF00);
        checkOutput("drv_pad_o", pad_o, 16'h00A5);
        checkRead("drv_rd_dout", 2'd0, 16'h00A5);
        checkRead("drv_rd_outen", 2'd1, 16'h00FF);
        tick(2);
        checkOutput("loop_early", in_data, 16'h0000);
        tick(1);
        checkOutput("loop_in", in_data, 16'h00A5);
        checkOutput("loop_irq", irq, 1'b1);
        checkRead("loop_stat", 2'd2, 16'h00A5);
        applyStimulus(2'd2, 16'hFFFF);
        checkOutput("clr_irq", irq, 1'b0);
        checkRead("clr_stat", 2'd2, 16'h0000);

        // Release every pad; external level is 0, so the looped pins fall.
        applyStimulus(2'd1, 16'h0000);
        checkOutput("rel_noe", pad_noe, 16'hFFFF);
        tick(4);
        checkOutput("rel_in", in_data, 16'h0000);
        checkRead("rel_stat", 2'd2, 16'h00A5);
        applyStimulus(2'd2, 16'hFFFF);
        checkOutput("rel_irq", irq, 1'b0);

        // Threshold 4: clean rise on pin 3 lands exactly 6 edges later.
        applyStimulus(2'd3, 16'h0004);
        ext_in[3] = 1'b1;
        tick(5);
        checkOutput("db_edge5", in_data, 16'h0000);
        tick(1);
        checkOutput("db_edge6", in_data, 16'h0008);
        checkOutput("db_irq", irq, 1'b1);
        checkRead("db_stat", 2'd2, 16'h0008);

        // 3-cycle glitch on pin 5 is discarded.
        ext_in[5] = 1'b1;
        tick(3);
        ext_in[5] = 1'b0;
        tick(8);
        checkOutput("glitch_in", in_data, 16'h0008);
        checkRead("glitch_stat", 2'd2, 16'h0008);

        // 4-cycle pulse on pin 6 is exactly long enough: rises then falls.
        ext_in[6] = 1'b1;
        tick(4);
        ext_in[6] = 1'b0;
        tick(12);
        checkOutput("pulse4_in", in_data, 16'h0008);
        checkRead("pulse4_stat", 2'd2, 16'h0048);

        // Clear collides with a new falling edge on pin 3: set wins.
        applyStimulus(2'd2, 16'hFFFF);
        checkOutput("pre_col_irq", irq, 1'b0);
        ext_in[3] = 1'b0;
        tick(5);
        applyStimulus(2'd2, 16'h0008);
        checkOutput("col_in", in_data, 16'h0000);
        checkRead("col_stat", 2'd2, 16'h0008);
        applyStimulus(2'd2, 16'h0008);
        checkOutput("col_clr_irq", irq, 1'b0);

        // Threshold rewrite mid-count restarts the count on pin 10.
        ext_in[10] = 1'b1;
        tick(4);
        applyStimulus(2'd3, 16'h0004);
        tick(3);
        checkOutput("thr_restart_e8", in_data, 16'h0000);
        tick(1);
        checkOutput("thr_restart_e9", in_data, 16'h0400);

        // Threshold 0 acts as 1.
        applyStimulus(2'd3, 16'h0000);
        ext_in[9] = 1'b1;
        tick(2);
        checkOutput("thr0_early", in_data, 16'h0400);
        tick(1);
        checkOutput("thr0_edge3", in_data, 16'h0600);

        // Reset in the middle of a debounce on pin 12.
        applyStimulus(2'd3, 16'h0004);
        ext_in[12] = 1'b1;
        tick(3);
        HRESETn = 1'b0;
        tick(1);
        HRESETn = 1'b1;
        checkOutput("mid_rst_in", in_data, 16'h0000);
        checkOutput("mid_rst_irq", irq, 1'b0);
        checkRead("mid_rst_stat", 2'd2, 16'h0000);
        checkOutput("mid_rst_noe", pad_noe, 16'hFFFF);
        tick(3);
        checkOutput("post_rst_in", in_data, 16'h1600);
        checkRead("post_rst_stat", 2'd2, 16'h1600);
        applyStimulus(2'd2, 16'hFFFF);

        // Drive pin 0 high while the bench holds the pad low.
        applyStimulus(2'd1, 16'h0001);
        force_mask[0] = 1'b1;
        ext_in[0]     = 1'b0;
        applyStimulus(2'd0, 16'h0001);
        tick(4);
        checkOutput("conf_early", conflict, 16'h0000);
        tick(1);
        checkOutput("conf_set", conflict, CONF_EN ? 16'h0001 : 16'h0000);
        force_mask[0] = 1'b0;
        tick(4);
        checkOutput("conf_sticky", conflict, CONF_EN ? 16'h0001 : 16'h0000);
        applyStimulus(2'd2, 16'h0001);
        checkOutput("conf_clr", conflict, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
